// File: rtl/conv_frame_ctrl_if.sv
// conv_frame_ctrl_if
//   Bundles the frame sequencer's two side buses: the image RAM read port and
//   the conv engine pixel stream.
//   master : sequencer side (drives RAM read strobe/address and conv inputs)
//   slave  : RAM + conv side (returns RAM data and conv result)
//   Signals:
//     mem_rd_en    RAM read strobe
//     mem_addr     RAM read address
//     mem_rd_data  RAM data, valid one cycle after mem_rd_en
//     conv_reset   clears conv line buffers
//     conv_pxl_in  pixel into conv
//     conv_pxl_out conv result
interface conv_frame_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              conv_reset;
  logic [7:0]        conv_pxl_in;
  logic [7:0]        conv_pxl_out;

  modport master (
    output mem_rd_en, mem_addr, conv_reset, conv_pxl_in,
    input  mem_rd_data, conv_pxl_out
  );

  modport slave (
    input  mem_rd_en, mem_addr, conv_reset, conv_pxl_in,
    output mem_rd_data, conv_pxl_out
  );
endinterface

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl
//   Frame sequencer for the streaming conv datapath. Reads one DIM x DIM 8-bit
//   image from sync RAM in raster order, feeds conv one pixel per cycle and
//   tags the conv output with valid/row/col where a full KxK window exists.
//   Ports:
//     clk_i, reset_i  clock / synchronous active-high reset
//     start_i         begin a frame (sampled only in IDLE)
//     frame_base_i    RAM address of pixel (0,0), latched on accepted start
//     busy_o          accepted start .. done cycle inclusive
//     done_o          one-cycle frame-complete pulse
//     out_valid_o     out_data_o is a full-window result
//     out_data_o      conv result when valid, else 0
//     out_row_o/col_o output window position 0..DIM-K
//     bus             RAM read port + conv stream (master modport)
//
//   state  | meaning
//   IDLE   | waiting for start
//   CLR    | one cycle of conv_reset before streaming
//   STREAM | DIM*DIM cycles, one RAM read per cycle
//   DRAIN  | 2+CONV_LAT cycles, read/conv pipeline empties
//   DONE   | one-cycle done pulse
module conv_frame_ctrl #(
  parameter int DIM      = 28,
  parameter int K        = 5,
  parameter int CONV_LAT = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] frame_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              out_valid_o,
  output logic [7:0]        out_data_o,
  output logic [7:0]        out_row_o,
  output logic [7:0]        out_col_o,
  conv_frame_ctrl_if.master bus
);
  localparam int NPIX    = DIM * DIM;
  localparam int TAG_D   = 2 + CONV_LAT;
  localparam int DRAIN_N = 2 + CONV_LAT;
  localparam int CNT_W   = $clog2(NPIX);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_STREAM, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic       ok;
    logic [7:0] row;
    logic [7:0] col;
  } tag_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        row_q, row_d;
  logic [7:0]        col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              conv_reset_q;
  logic              rdv_q;
  logic [7:0]        pxl_q;
  tag_t              tag_q [TAG_D];
  tag_t              tag_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLR;
          addr_d  = frame_base_i;
        end
      end
      S_CLR: begin
        state_d = S_STREAM;
        cnt_d   = CNT_W'(NPIX - 1);
        row_d   = '0;
        col_d   = '0;
      end
      S_STREAM: begin
        addr_d = addr_q + 1'b1;
        if (col_q == 8'(DIM - 1)) begin
          col_d = '0;
          row_d = row_q + 8'd1;
        end else begin
          col_d = col_q + 8'd1;
        end
        // cnt_q holds pixels remaining minus one; terminal count ends the stream
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(DRAIN_N - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tag for the pixel being read this cycle; it rides the shift register so
  // it lines up with the conv result TAG_D cycles later.
  always_comb begin
    tag_in = '0;
    if (state_q == S_STREAM && row_q >= 8'(K - 1) && col_q >= 8'(K - 1)) begin
      tag_in.ok  = 1'b1;
      tag_in.row = row_q - 8'(K - 1);
      tag_in.col = col_q - 8'(K - 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      conv_reset_q <= 1'b1;
      rdv_q        <= 1'b0;
      pxl_q        <= '0;
      for (int i = 0; i < TAG_D; i++) tag_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      conv_reset_q <= (state_d == S_CLR);
      rdv_q        <= (state_q == S_STREAM);
      // zero outside fed cycles so conv never sees stale RAM data
      pxl_q        <= rdv_q ? bus.mem_rd_data : 8'd0;
      tag_q[0]     <= tag_in;
      for (int i = 1; i < TAG_D; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign bus.mem_rd_en   = (state_q == S_STREAM);
  assign bus.mem_addr    = addr_q;
  assign bus.conv_reset  = conv_reset_q;
  assign bus.conv_pxl_in = pxl_q;
  assign out_valid_o     = tag_q[TAG_D-1].ok;
  assign out_row_o       = tag_q[TAG_D-1].row;
  assign out_col_o       = tag_q[TAG_D-1].col;
  assign out_data_o      = tag_q[TAG_D-1].ok ? bus.conv_pxl_out : 8'd0;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
module tb_conv_frame_ctrl;
  localparam int DIM      = 28;
  localparam int K        = 5;
  localparam int CONV_LAT = 1;
  localparam int ADDR_W   = 16;
  localparam int NPIX     = DIM * DIM;
  localparam int OUTW     = DIM - K + 1;
  localparam int NOUT     = OUTW * OUTW;
  // frame timeline relative to the accepted-start cycle (k = 0)
  localparam int K_DONE   = NPIX + 4 + CONV_LAT;
  localparam int K_RES0   = 4 + CONV_LAT;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] frame_base = '0;
  logic              busy, done, out_valid;
  logic [7:0]        out_data, out_row, out_col;

  conv_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  conv_frame_ctrl #(.DIM(DIM), .K(K), .CONV_LAT(CONV_LAT), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .frame_base_i(frame_base),
    .busy_o      (busy),
    .done_o      (done),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_row_o   (out_row),
    .out_col_o   (out_col),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // image RAM and a conv stand-in that is a plain 1-cycle delay
  logic [7:0] mem [65536];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  always @(posedge clk) bus.conv_pxl_out <= bus.conv_pxl_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int                m_k = -1;   // cycles since accepted start, -1 when idle
  logic [ADDR_W-1:0] m_base = '0;
  bit                m_rst = 1'b0;
  bit                m_live = 1'b0;
  bit                lit_frame = 1'b0;  // directed frame: base 0x100, image[n]=n

  always @(posedge clk) begin
    if (reset) begin
      m_k = -1; m_rst = 1'b1; m_live = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (m_k < 0) begin
        if (start) begin m_k = 1; m_base = frame_base; end
      end else if (m_k == K_DONE) m_k = -1;
      else m_k = m_k + 1;
    end
  end

  int         g_done = 0;
  int         f_val, first_k, last_k;
  logic [15:0] first_rc, last_rc, a_first, a_last, a_w16, a_w15;

  always @(negedge clk) begin
    if (m_live) begin
      logic              busy_e, done_e, rd_e, crst_e, v_e;
      logic [ADDR_W-1:0] addr_e, idx;
      logic [7:0]        pxl_e, data_e, row_e, col_e;
      int                n;
      busy_e = (m_k >= 1);
      done_e = (m_k == K_DONE);
      rd_e   = (m_k >= 2 && m_k <= NPIX + 1);
      crst_e = m_rst || (m_k == 1);
      addr_e = m_base + ADDR_W'(m_k - 2);
      idx    = m_base + ADDR_W'(m_k - 4);
      pxl_e  = (m_k >= 4 && m_k <= NPIX + 3) ? mem[idx] : 8'd0;
      n      = m_k - K_RES0;
      v_e    = (m_k >= 0) && (n >= 0) && (n < NPIX) && (n / DIM >= K - 1) && (n % DIM >= K - 1);
      row_e  = 8'(n / DIM - (K - 1));
      col_e  = 8'(n % DIM - (K - 1));
      idx    = m_base + ADDR_W'(n);
      data_e = v_e ? mem[idx] : 8'd0;

      chk("ctrl{busy,done,rd_en,conv_reset}", {busy, done, bus.mem_rd_en, bus.conv_reset},
          {busy_e, done_e, rd_e, crst_e});
      if (rd_e) chk("mem_addr", bus.mem_addr, addr_e);
      chk("conv_pxl_in", bus.conv_pxl_in, pxl_e);
      chk("out{valid,data}", {out_valid, out_data}, {v_e, data_e});
      if (v_e) chk("out{row,col}", {out_row, out_col}, {row_e, col_e});

      // frame tallies and literal pins
      if (m_k == 1) begin f_val = 0; first_k = -1; last_k = -1; end
      if (m_k == 2)        a_first = bus.mem_addr;
      if (m_k == NPIX + 1) a_last  = bus.mem_addr;
      if (m_k == 17)       a_w15   = bus.mem_addr;
      if (m_k == 18)       a_w16   = bus.mem_addr;
      if (out_valid === 1'b1) begin
        f_val++;
        if (first_k < 0) begin first_k = m_k; first_rc = {out_row, out_col}; end
        last_k = m_k; last_rc = {out_row, out_col};
        if (lit_frame && m_k >= 0)
          chk("t3_data", out_data, 64'((((out_row + 4) * 28) + out_col + 4) & 8'hFF));
      end
      if (done === 1'b1) begin
        g_done++;
        chk("done_cycle", m_k, 789);
      end
      if (m_k == K_DONE) begin
        chk("frame_out_count", f_val, 576);
        if (lit_frame) begin
          chk("first_out{k,row,col}", {first_k[15:0], first_rc}, {16'd121, 8'd0, 8'd0});
          chk("last_out{k,row,col}", {last_k[15:0], last_rc}, {16'd788, 8'd23, 8'd23});
          chk("addr_range", {a_first, a_last}, {16'h0100, 16'h040F});
        end
        if (m_base == 16'hFFF0) chk("addr_wrap", {a_w15, a_w16}, {16'hFFFF, 16'h0000});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 2000) begin step(1); c++; end
    if (c >= 2000) begin
      n_checks++; n_errors++;
      $display("FAIL %s: timeout waiting for busy low, got busy=%b required 0", name, busy);
    end
  endtask

  task automatic check_rst(input string name);
    chk(name, {busy, done, out_valid, bus.mem_rd_en, bus.conv_reset, out_data, out_row,
               out_col, bus.mem_addr, bus.conv_pxl_in},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 16'd0, 8'd0});
  endtask

  initial begin
    int gd;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // 1: reset held 3 cycles with start high
    start = 1'b1;
    frame_base = 16'h1234;
    for (int i = 0; i < 3; i++) begin @(negedge clk); check_rst("t1_reset_state"); end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    step(2);

    // 2/3: directed frame, base 0x100, image[n] = n & 0xFF
    for (int n = 0; n < NPIX; n++) mem[16'h0100 + n] = 8'(n);
    lit_frame = 1'b1;
    frame_base = 16'h0100; start = 1'b1;
    step(1); start = 1'b0;
    wait_idle("t2_frame");
    step(2);
    lit_frame = 1'b0;

    // 4: start held for the whole frame, released in the first idle cycle
    gd = g_done;
    frame_base = 16'($urandom); start = 1'b1;
    step(K_DONE + 1); start = 1'b0;
    step(3);
    chk("t4_done_count", g_done - gd, 1);

    // 5: reset mid-frame, then a clean frame
    gd = g_done;
    frame_base = 16'($urandom); start = 1'b1;
    step(1); start = 1'b0;
    step(398);
    reset = 1'b1;
    step(1);
    check_rst("t5_abort_state");
    reset = 1'b0;
    step(900);
    chk("t5_no_done", g_done - gd, 0);
    frame_base = 16'($urandom); start = 1'b1;
    step(1); start = 1'b0;
    wait_idle("t5_clean_frame");
    step(2);

    // 6: address wrap
    frame_base = 16'hFFF0; start = 1'b1;
    step(1); start = 1'b0;
    wait_idle("t6_wrap_frame");
    step(2);

    // randomized frames: random base, random start chatter, occasional abort
    for (int f = 0; f < 6; f++) begin
      int  cyc, ab_at;
      bit  abort;
      step($urandom_range(0, 4));
      frame_base = 16'($urandom); start = 1'b1;
      step(1);
      abort = ($urandom_range(0, 3) == 0);
      ab_at = $urandom_range(10, 780);
      cyc = 0;
      while (busy === 1'b1 && cyc < 2000) begin
        start = ($urandom_range(0, 3) == 0);
        reset = (abort && cyc == ab_at);
        step(1);
        cyc++;
      end
      if (cyc >= 2000) begin
        n_checks++; n_errors++;
        $display("FAIL rand_frame: timeout, got busy=%b required 0", busy);
      end
      start = 1'b0; reset = 1'b0;
      step(1);
      wait_idle("rand_tail");
      step(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
